assoc_cache_wb: RTL and testbench
=================================

ASSOC_CACHE_WB -- requirements
Module: assoc_cache_wb

Interface
REQ-001 Parameters SHALL be: SETS, default 4, number of sets (power of 2, >=2); WAYS, default 4, ways per set (power of 2, >=2); ADDR_W, default 5, address bits; DATA_W, default 3, data bits per line.
REQ-002 Derived widths SHALL be IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W, AGE_W=log2(WAYS); index=addr[IDX_W-1:0], tag=addr[ADDR_W-1:IDX_W].
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when req_valid&&req_ready.
REQ-007 req_wr  in  1  1=write, 0=read.
REQ-008 req_addr  in  ADDR_W  request address.
REQ-009 req_wdata  in  DATA_W  write data.
REQ-010 rsp_valid  out  1  one-cycle response strobe.
REQ-011 rsp_data  out  DATA_W  read data, or written data for writes.
REQ-012 rsp_hit  out  1  1=request hit in cache.
REQ-013 mem_valid  out  1  backing-memory transfer request.
REQ-014 mem_wr  out  1  1=writeback, 0=refill read.
REQ-015 mem_addr  out  ADDR_W  memory address.
REQ-016 mem_wdata  out  DATA_W  writeback data.
REQ-017 mem_ready  in  1  transfer complete when mem_valid&&mem_ready; mem_rdata valid that cycle.
REQ-018 mem_rdata  in  DATA_W  refill data.

Function
REQ-019 Each line SHALL hold valid, dirty, tag, data; each set SHALL hold one AGE_W age per way (0=most recent).
REQ-020 FSM states SHALL be IDLE, LOOKUP, WRITEBACK, REFILL, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE: on handshake, register wr/addr/wdata, go LOOKUP; requests while not IDLE are not accepted.
REQ-022 LOOKUP: hit = any way valid with matching tag (at most one); hit -> RESP.
REQ-023 Read hit: rsp_data=line data; write hit: line data=wdata, dirty=1.
REQ-024 Miss victim: lowest-index invalid way; else way whose age=WAYS-1.
REQ-025 Miss with valid dirty victim -> WRITEBACK; otherwise read miss -> REFILL, write miss -> RESP.
REQ-026 WRITEBACK: mem_valid=1, mem_wr=1, mem_addr={victim tag,index}, mem_wdata=victim data, all held stable until mem_ready; then read miss -> REFILL, write miss -> RESP.
REQ-027 REFILL: mem_valid=1, mem_wr=0, mem_addr=req addr, held until mem_ready; capture mem_rdata into victim (valid=1, dirty=0, new tag); -> RESP.
REQ-028 Write miss SHALL install victim with wdata, valid=1, dirty=1, no refill (write-allocate, one word per line).
REQ-029 mem_ready in the first cycle of mem_valid SHALL complete the transfer; mem_ready while mem_valid=0 ignored.
REQ-030 RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_hit, -> IDLE; hit latency = rsp_valid 2 cycles after handshake cycle.
REQ-031 Age update on every completed access to way w (hit or install): ways with age<age[w] +1, age[w]=0; ages in a set remain a permutation of 0..WAYS-1.
REQ-032 rsp_data/rsp_hit SHALL hold last response value outside RESP; mem_* outputs SHALL be 0 when mem_valid=0.

Reset
REQ-033 resetn=0 SHALL immediately force: state IDLE, all valid/dirty=0, ages of way i=i in every set, all outputs 0 except req_ready=1 once deasserted... req_ready=0 while resetn=0.
REQ-034 Reset mid-transfer SHALL abandon the transaction (no response, dirty data lost) and drop mem_valid asynchronously.

Verification (defaults: index=addr[1:0], tag=addr[4:2])
REQ-035 Read 0x05 after reset -> mem read addr 0x05, mem_rdata=6 -> rsp_data=6, rsp_hit=0; reread 0x05 -> rsp_hit=1, data 6, no mem_valid, rsp 2 cycles after handshake.
REQ-036 Write 0x01 data 3 after reset -> no mem traffic, rsp_hit=0; read 0x01 -> rsp_hit=1, rsp_data=3.
REQ-037 Read 0x00,0x04,0x08,0x0C, reread 0x00, read 0x10 -> refill of 0x10 replaces line of 0x04; read 0x04 -> miss, 0x00 -> hit.
REQ-038 Write 0x00,0x04,0x08,0x0C data 1,2,3,4; read 0x10 -> mem write addr 0x00 data 1, then mem read 0x10, rsp_hit=0.
REQ-039 Hold mem_ready=0 3 cycles in WRITEBACK -> mem_valid/mem_addr/mem_wdata stable; req_valid pulses ignored.
REQ-040 resetn=0 during REFILL -> mem_valid=0 same cycle, no rsp_valid; after release read of prior-hit address misses.

Source files
------------

// File: rtl/assoc_cache_wb.sv
// Set-associative write-back, write-allocate cache with per-set LRU age ranks.
// One word per line; misses are serviced through a single-beat backing-memory port.
module assoc_cache_wb #(
  parameter int SETS   = 4,
  parameter int WAYS   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              mem_valid,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_WRITEBACK, ST_REFILL, ST_RESP} state_t;
  state_t state_q, state_d;

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [AGE_W-1:0]  victim_q, victim_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_hit_q, rsp_hit_d;

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic              hit_s, inv_found_s;
  logic [AGE_W-1:0]  hit_way_s, inv_way_s, lru_way_s, miss_way_s;
  logic              upd_en_s, upd_dirty_s;
  logic [AGE_W-1:0]  upd_way_s;
  logic [DATA_W-1:0] upd_data_s;

  assign idx_s = addr_q[IDX_W-1:0];
  assign tag_s = addr_q[ADDR_W-1:IDX_W];

  // Tag match plus victim choice: lowest invalid way first, otherwise the oldest way.
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = {AGE_W{1'b0}};
    inv_found_s = 1'b0;
    inv_way_s   = {AGE_W{1'b0}};
    lru_way_s   = {AGE_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      hit_way_s   = (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) ? AGE_W'(w) : hit_way_s;
      hit_s       = hit_s | (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s));
      lru_way_s   = (age_q[idx_s][w] == AGE_W'(WAYS - 1)) ? AGE_W'(w) : lru_way_s;
      inv_way_s   = (!valid_q[idx_s][w] && !inv_found_s) ? AGE_W'(w) : inv_way_s;
      inv_found_s = inv_found_s | !valid_q[idx_s][w];
    end
    miss_way_s = inv_found_s ? inv_way_s : lru_way_s;
  end

  // Next-state logic; upd_* describes the single line write of a completed access.
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    upd_en_s    = 1'b0;
    upd_way_s   = victim_q;
    upd_dirty_s = 1'b1;
    upd_data_s  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_LOOKUP;
        else           state_d = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          upd_en_s   = 1'b1;
          upd_way_s  = hit_way_s;
          rsp_hit_d  = 1'b1;
          state_d    = ST_RESP;
          if (wr_q) begin
            rsp_data_d = wdata_q;
          end else begin
            upd_dirty_s = dirty_q[idx_s][hit_way_s];
            upd_data_s  = data_q[idx_s][hit_way_s];
            rsp_data_d  = data_q[idx_s][hit_way_s];
          end
        end else begin
          victim_d = miss_way_s;
          if (valid_q[idx_s][miss_way_s] && dirty_q[idx_s][miss_way_s]) begin
            state_d = ST_WRITEBACK;
          end else if (!wr_q) begin
            state_d = ST_REFILL;
          end else begin
            upd_en_s   = 1'b1;
            upd_way_s  = miss_way_s;
            rsp_data_d = wdata_q;
            rsp_hit_d  = 1'b0;
            state_d    = ST_RESP;
          end
        end
      end
      ST_WRITEBACK: begin
        if (mem_ready && wr_q) begin
          upd_en_s   = 1'b1;
          rsp_data_d = wdata_q;
          rsp_hit_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (mem_ready) begin
          state_d = ST_REFILL;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_REFILL: begin
        if (mem_ready) begin
          upd_en_s    = 1'b1;
          upd_dirty_s = 1'b0;
          upd_data_s  = mem_rdata;
          rsp_data_d  = mem_rdata;
          rsp_hit_d   = 1'b0;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      victim_q   <= {AGE_W{1'b0}};
      rsp_data_q <= {DATA_W{1'b0}};
      rsp_hit_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      rsp_data_q <= rsp_data_d;
      rsp_hit_q  <= rsp_hit_d;
      if (state_q == ST_IDLE && req_valid) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Line storage and age ranks; the touched way becomes youngest, younger ways age by one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= {TAG_W{1'b0}};
          data_q[s][w]  <= {DATA_W{1'b0}};
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else if (upd_en_s) begin
      valid_q[idx_s][upd_way_s] <= 1'b1;
      dirty_q[idx_s][upd_way_s] <= upd_dirty_s;
      tag_q[idx_s][upd_way_s]   <= tag_s;
      data_q[idx_s][upd_way_s]  <= upd_data_s;
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == upd_way_s)
          age_q[idx_s][w] <= {AGE_W{1'b0}};
        else if (age_q[idx_s][w] < age_q[idx_s][upd_way_s])
          age_q[idx_s][w] <= age_q[idx_s][w] + AGE_W'(1);
      end
    end
  end

  // Memory port driven straight from state so reset drops it immediately.
  always_comb begin
    mem_valid = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (state_q == ST_WRITEBACK) begin
      mem_valid = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = {tag_q[idx_s][victim_q], idx_s};
      mem_wdata = data_q[idx_s][victim_q];
    end else if (state_q == ST_REFILL) begin
      mem_valid = 1'b1;
      mem_addr  = addr_q;
    end else begin
      mem_valid = 1'b0;
    end
  end

  assign req_ready = resetn && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;

endmodule

// File: tb/tb_assoc_cache_wb.sv
// Directed, table-driven bench for assoc_cache_wb (default parameters) with a
// responsive backing-memory model and hand sequences for stalls and mid-refill reset.
module tb_assoc_cache_wb;
  logic       clock, resetn;
  logic       req_valid, req_ready, req_wr;
  logic [4:0] req_addr;
  logic [2:0] req_wdata;
  logic       rsp_valid, rsp_hit;
  logic [2:0] rsp_data;
  logic       mem_valid, mem_wr, mem_ready;
  logic [4:0] mem_addr;
  logic [2:0] mem_wdata, mem_rdata;

  assoc_cache_wb dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit wr; logic [4:0] addr; logic [2:0] wdata; int lat; bit pulse;
    logic [2:0] exp_data; bit exp_hit; int exp_wb; int exp_rd;
    logic [4:0] exp_wb_addr; logic [2:0] exp_wb_data;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  logic [2:0] model [32];

  int tests = 0, fails = 0;
  logic [2:0] got_data, got_wb_data;
  logic [4:0] got_wb_addr;
  bit got_hit, got_stable, got_timeout;
  int got_cyc, got_nwb, got_nrd;

  function automatic vec_t mk(bit rst, bit wr, int addr, int wdata, int lat, bit pulse,
                              int ed, bit eh, int ewb, int erd, int ewa, int ewd);
    vec_t v;
    v.rst = rst; v.wr = wr; v.addr = 5'(addr); v.wdata = 3'(wdata); v.lat = lat; v.pulse = pulse;
    v.exp_data = 3'(ed); v.exp_hit = eh; v.exp_wb = ewb; v.exp_rd = erd;
    v.exp_wb_addr = 5'(ewa); v.exp_wb_data = 3'(ewd);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic init_model();
    for (int a = 0; a < 32; a++) model[a] = 3'(a + 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    check("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rsp_data", {29'd0, rsp_data}, 32'd0);
    check("rst rsp_hit", {31'd0, rsp_hit}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    init_model();
    #1;
    check("post-rst req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // One request; answers memory transfers after lat stall cycles and records what the DUT did.
  task automatic run_req(input bit wr, input logic [4:0] addr, input logic [2:0] wdata,
                         input int lat, input bit pulse);
    int k, waitc;
    bit cap_wr;
    logic [4:0] cap_addr;
    logic [2:0] cap_wdata;
    got_timeout = 1'b1; got_stable = 1'b1; got_nwb = 0; got_nrd = 0; got_cyc = 0;
    got_data = 3'd0; got_hit = 1'b0; got_wb_addr = 5'd0; got_wb_data = 3'd0;
    cap_wr = 1'b0; cap_addr = 5'd0; cap_wdata = 3'd0;
    @(negedge clock);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    k = 0; waitc = 0;
    while (got_timeout && k < 60) begin
      @(negedge clock);
      k++;
      req_valid = 1'b0;
      mem_ready = 1'b0;
      if (rsp_valid) begin
        got_data = rsp_data; got_hit = rsp_hit; got_cyc = k; got_timeout = 1'b0;
      end else if (mem_valid) begin
        if (waitc == 0) begin
          cap_wr = mem_wr; cap_addr = mem_addr; cap_wdata = mem_wdata;
        end else if (mem_wr !== cap_wr || mem_addr !== cap_addr ||
                     mem_wdata !== cap_wdata || req_ready !== 1'b0) begin
          got_stable = 1'b0;
        end
        if (waitc >= lat) begin
          mem_ready = 1'b1;
          if (mem_wr) begin
            got_nwb++; got_wb_addr = mem_addr; got_wb_data = mem_wdata;
            model[mem_addr] = mem_wdata;
          end else begin
            got_nrd++; mem_rdata = model[mem_addr];
          end
          waitc = 0;
        end else begin
          waitc++;
          if (pulse && (waitc % 2 == 1)) req_valid = 1'b1;
        end
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    clock = 1'b0; resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    req_addr = 5'd0; req_wdata = 3'd0; mem_ready = 1'b0; mem_rdata = 3'd0;
    init_model();
    //          rst wr addr  wd lat pl  data hit wb rd wbaddr wbdata
    vecs[0]  = mk(1, 0, 'h05, 0, 0, 0,  6, 0, 0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 'h05, 0, 0, 0,  6, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 'h01, 3, 0, 0,  3, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 'h01, 0, 0, 0,  3, 1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 'h04, 0, 1, 0,  5, 0, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 'h08, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    vecs[7]  = mk(0, 0, 'h0C, 0, 0, 0,  5, 0, 0, 1, 0, 0);
    vecs[8]  = mk(0, 0, 'h00, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 'h10, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    vecs[10] = mk(0, 0, 'h04, 0, 0, 0,  5, 0, 0, 1, 0, 0);
    vecs[11] = mk(0, 0, 'h00, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    vecs[12] = mk(1, 1, 'h00, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 'h04, 2, 0, 0,  2, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 'h08, 3, 0, 0,  3, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 1, 'h0C, 4, 0, 0,  4, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 'h10, 0, 3, 1,  1, 0, 1, 1, 'h00, 1);
    vecs[17] = mk(0, 0, 'h00, 0, 0, 0,  1, 0, 1, 1, 'h04, 2);
    vecs[18] = mk(0, 1, 'h0C, 6, 0, 0,  6, 1, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 'h0C, 0, 0, 0,  6, 1, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 'h14, 7, 2, 1,  7, 0, 1, 0, 'h08, 3);
    vecs[21] = mk(0, 0, 'h14, 0, 0, 0,  7, 1, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      run_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].pulse);
      check($sformatf("v%0d timeout", i), {31'd0, got_timeout}, 32'd0);
      check($sformatf("v%0d rsp_data", i), {29'd0, got_data}, {29'd0, vecs[i].exp_data});
      check($sformatf("v%0d rsp_hit", i), {31'd0, got_hit}, {31'd0, vecs[i].exp_hit});
      check($sformatf("v%0d writebacks", i), got_nwb, vecs[i].exp_wb);
      check($sformatf("v%0d refills", i), got_nrd, vecs[i].exp_rd);
      check($sformatf("v%0d mem stable", i), {31'd0, got_stable}, 32'd1);
      if (vecs[i].exp_hit)
        check($sformatf("v%0d hit latency", i), got_cyc, 2);
      if (vecs[i].exp_wb > 0) begin
        check($sformatf("v%0d wb addr", i), {27'd0, got_wb_addr}, {27'd0, vecs[i].exp_wb_addr});
        check($sformatf("v%0d wb data", i), {29'd0, got_wb_data}, {29'd0, vecs[i].exp_wb_data});
      end
      @(negedge clock);
      check($sformatf("v%0d rsp one-shot", i), {31'd0, rsp_valid}, 32'd0);
      check($sformatf("v%0d rsp_data hold", i), {29'd0, rsp_data}, {29'd0, vecs[i].exp_data});
      check($sformatf("v%0d rsp_hit hold", i), {31'd0, rsp_hit}, {31'd0, vecs[i].exp_hit});
      check($sformatf("v%0d idle mem_addr", i), {26'd0, mem_valid, mem_addr}, 32'd0);
    end

    // Reset while a refill is outstanding.
    do_reset();
    run_req(1'b0, 5'h05, 3'd0, 0, 1'b0);
    check("mr first read hit", {31'd0, got_hit}, 32'd0);
    run_req(1'b0, 5'h05, 3'd0, 0, 1'b0);
    check("mr reread hit", {31'd0, got_hit}, 32'd1);
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'h09;
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !mem_valid; k++) @(negedge clock);
    check("mr refill valid", {31'd0, mem_valid}, 32'd1);
    check("mr refill addr", {26'd0, mem_wr, mem_addr}, 32'h09);
    #2;
    resetn = 1'b0;
    #1;
    check("mr mem_valid drop", {31'd0, mem_valid}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("mr no rsp", {31'd0, rsp_valid}, 32'd0);
    end
    resetn = 1'b1;
    init_model();
    run_req(1'b0, 5'h05, 3'd0, 0, 1'b0);
    check("mr after-reset timeout", {31'd0, got_timeout}, 32'd0);
    check("mr after-reset hit", {31'd0, got_hit}, 32'd0);
    check("mr after-reset data", {29'd0, got_data}, 32'd6);
    check("mr after-reset refills", got_nrd, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
